// File: rtl/weight_tile_loader.sv
// weight_tile_loader: streams one Tm x Tn x K x K weight tile from the weight RAM to
// weight_filter in k0 (inner), k1, tm, tn (outer) order. Out-of-range channels are pushed
// as zero without a RAM read. A RD_LAT-deep {valid,legal} pipe realigns issued slots with
// returning read data.
// Optional build macro WEIGHT_LOADER_STAT_EN adds the stall_cycles statistics port.
module weight_tile_loader #(
   parameter int unsigned AW     = 16,
   parameter int unsigned CW     = 16,
   parameter int unsigned DW     = 32,
   parameter int unsigned N      = 32,
   parameter int unsigned M      = 32,
   parameter int unsigned K      = 3,
   parameter int unsigned Tn     = 16,
   parameter int unsigned Tm     = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] tile_base_m,
   input  logic [CW-1:0] tile_base_n,
   input  logic [AW-1:0] weight_base_addr,
   input  logic          fifo_almost_full,
   output logic          rd_ena,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          fifo_push_tmp,
   output logic [DW-1:0] data_to_fifo_tmp,
   output logic          busy,
   output logic          done
`ifdef WEIGHT_LOADER_STAT_EN
   ,
   output logic [31:0]   stall_cycles
`endif
);

   localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned TMW = (Tm > 1) ? $clog2(Tm) : 1;
   localparam int unsigned TNW = (Tn > 1) ? $clog2(Tn) : 1;
   // All pipe stages except the tail; empty here means the pipe is empty next cycle.
   localparam logic [RD_LAT-1:0] HeadMask = {RD_LAT{1'b1}} >> 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   k0_q, k1_q;
   logic [TMW-1:0]  tm_q;
   logic [TNW-1:0]  tn_q;
   logic [CW-1:0]   base_m_q, base_n_q;
   logic [AW-1:0]   base_addr_q, rd_addr_q, addr_calc;
   logic [RD_LAT-1:0] vld_q, lgl_q;
   logic [CW:0]     m_idx, n_idx;
   logic            legal, issue, last_elem, start_ok;

   // Channel indices are one bit wider than the bases so base+offset cannot wrap.
   assign m_idx     = {1'b0, base_m_q} + (CW+1)'(tm_q);
   assign n_idx     = {1'b0, base_n_q} + (CW+1)'(tn_q);
   assign legal     = (m_idx < (CW+1)'(M)) && (n_idx < (CW+1)'(N));
   assign issue     = (state_q == StIssue) && !fifo_almost_full;
   assign start_ok  = (state_q == StIdle) && start;
   assign last_elem = (k0_q == KW'(K-1)) && (k1_q == KW'(K-1)) &&
                      (tm_q == TMW'(Tm-1)) && (tn_q == TNW'(Tn-1));
   assign addr_calc = base_addr_q + AW'(((32'(m_idx) * N + 32'(n_idx)) * K + 32'(k1_q)) * K
                                        + 32'(k0_q));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (issue && last_elem) state_d = StDrain;
         StDrain: if ((vld_q & HeadMask) == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; illegal slots leave the address bus at its last driven value.
   always_comb begin
      rd_ena  = issue && legal;
      rd_addr = rd_ena ? addr_calc : rd_addr_q;
      busy    = (state_q == StIssue) || (state_q == StDrain);
      done    = (state_q == StDone);
   end

   // Tile bases captured on start; element counters advance one slot per issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_m_q    <= '0;
         base_n_q    <= '0;
         base_addr_q <= '0;
         k0_q        <= '0;
         k1_q        <= '0;
         tm_q        <= '0;
         tn_q        <= '0;
      end else if (start_ok) begin
         base_m_q    <= tile_base_m;
         base_n_q    <= tile_base_n;
         base_addr_q <= weight_base_addr;
         k0_q        <= '0;
         k1_q        <= '0;
         tm_q        <= '0;
         tn_q        <= '0;
      end else if (issue) begin
         if (k0_q != KW'(K-1)) begin
            k0_q <= k0_q + 1'b1;
         end else begin
            k0_q <= '0;
            if (k1_q != KW'(K-1)) begin
               k1_q <= k1_q + 1'b1;
            end else begin
               k1_q <= '0;
               if (tm_q != TMW'(Tm-1)) begin
                  tm_q <= tm_q + 1'b1;
               end else begin
                  tm_q <= '0;
                  tn_q <= (tn_q == TNW'(Tn-1)) ? '0 : tn_q + 1'b1;
               end
            end
         end
      end
   end

   // Last driven read address, held across illegal slots.
   always_ff @(posedge clk) begin
      if (rst)         rd_addr_q <= '0;
      else if (rd_ena) rd_addr_q <= addr_calc;
   end

   // Latency pipe: the tail lines up with the read data of the slot issued RD_LAT ago.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         lgl_q <= '0;
      end else begin
         vld_q[0] <= issue;
         lgl_q[0] <= issue && legal;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            lgl_q[i] <= lgl_q[i-1];
         end
      end
   end

   assign fifo_push_tmp    = vld_q[RD_LAT-1];
   assign data_to_fifo_tmp = lgl_q[RD_LAT-1] ? rd_data : '0;

`ifdef WEIGHT_LOADER_STAT_EN
   // Saturating count of issue cycles lost to downstream back-pressure.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         stall_cycles <= '0;
      end else if ((state_q == StIssue) && fifo_almost_full && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_weight_tile_loader.sv
// Testbench for weight_tile_loader: a RAM model with fixed latency feeds the DUT while a
// scoreboard holds the expected address and data streams for each tile.
module tb_weight_tile_loader;

   localparam int RD_LAT = 2;
   localparam int TOTAL  = 16 * 16 * 3 * 3;

   logic        clk, rst, start;
   logic [15:0] tile_base_m, tile_base_n, weight_base_addr;
   logic        fifo_almost_full;
   logic        rd_ena;
   logic [15:0] rd_addr;
   logic [31:0] rd_data;
   logic        fifo_push_tmp;
   logic [31:0] data_to_fifo_tmp;
   logic        busy, done;
`ifdef WEIGHT_LOADER_STAT_EN
   logic [31:0] stall_cycles;
`endif

   weight_tile_loader u_dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .tile_base_m      (tile_base_m),
      .tile_base_n      (tile_base_n),
      .weight_base_addr (weight_base_addr),
      .fifo_almost_full (fifo_almost_full),
      .rd_ena           (rd_ena),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data),
      .fifo_push_tmp    (fifo_push_tmp),
      .data_to_fifo_tmp (data_to_fifo_tmp),
      .busy             (busy),
      .done             (done)
`ifdef WEIGHT_LOADER_STAT_EN
      ,
      .stall_cycles     (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: word content derived from its address, returned RD_LAT cycles later.
   logic [31:0] ram_p0, ram_p1;
   always @(posedge clk) begin
      ram_p0 <= rd_ena ? {16'hBEEF, rd_addr} : 32'hDEADDEAD;
      ram_p1 <= ram_p0;
   end
   assign rd_data = ram_p1;

   logic [31:0] exp_data_q[$];
   logic [15:0] exp_addr_q[$];
   int vectors, miscompares, pushes_seen, nonzero_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: every read and every push is checked against the scoreboard.
   always @(negedge clk) begin
      if (fifo_push_tmp === 1'b1) begin
         pushes_seen++;
         if (data_to_fifo_tmp != 32'd0) nonzero_seen++;
         if (exp_data_q.size() == 0) check("push_unexpected", {31'd0, fifo_push_tmp}, 32'd0);
         else check("push_data", data_to_fifo_tmp, exp_data_q.pop_front());
      end
      if (rd_ena === 1'b1) begin
         if (exp_addr_q.size() == 0) check("read_unexpected", {31'd0, rd_ena}, 32'd0);
         else check("rd_addr", {16'd0, rd_addr}, {16'd0, exp_addr_q.pop_front()});
      end
   end

   task automatic fill(input int bm, input int bn, input logic [15:0] base);
      logic [15:0] a;
      for (int tn = 0; tn < 16; tn++)
         for (int tm = 0; tm < 16; tm++)
            for (int k1 = 0; k1 < 3; k1++)
               for (int k0 = 0; k0 < 3; k0++) begin
                  if ((bm + tm < 32) && (bn + tn < 32)) begin
                     a = 16'(int'(base) + (((bm + tm) * 32 + bn + tn) * 3 + k1) * 3 + k0);
                     exp_addr_q.push_back(a);
                     exp_data_q.push_back({16'hBEEF, a});
                  end else begin
                     exp_data_q.push_back(32'd0);
                  end
               end
   endtask

   // One tile. stall toggles almost-full 1-of-3 cycles; start_again re-pulses start at that
   // cycle; abort_at applies reset once that many pushes have been seen.
   task automatic run_tile(input int bm, input int bn, input logic [15:0] base, input bit stall,
                           input int start_again, input int abort_at);
      int stalls = 0;
      int issued = 0;
      int done_c = -1;
      fill(bm, bn, base);
      pushes_seen  = 0;
      nonzero_seen = 0;
      tile_base_m      = 16'(bm);
      tile_base_n      = 16'(bn);
      weight_base_addr = base;
      start            = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 4000; c++) begin
         fifo_almost_full = stall && (c % 3 == 0);
         if (issued < TOTAL) begin
            if (fifo_almost_full) stalls++;
            else issued++;
         end
         start = (c == start_again);
         if (start) begin
            tile_base_m      = 16'd3;
            tile_base_n      = 16'd5;
            weight_base_addr = 16'h1234;
         end
         @(negedge clk);
         if (c == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
         if (done === 1'b1) begin
            done_c = c;
            break;
         end
         if (abort_at > 0 && pushes_seen >= abort_at) break;
         @(posedge clk); #1;
      end
      if (abort_at > 0) begin
         start = 1'b0;
         fifo_almost_full = 1'b0;
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         exp_data_q.delete();
         exp_addr_q.delete();
         @(negedge clk);
         check("busy_after_rst", {31'd0, busy}, 32'd0);
         check("push_after_rst", {31'd0, fifo_push_tmp}, 32'd0);
         repeat (6) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
         end
      end else begin
         @(posedge clk); #1;
         start = 1'b0;
         fifo_almost_full = 1'b0;
         check("done_cycle", done_c, TOTAL + RD_LAT + 1 + stalls);
         check("push_count", pushes_seen, TOTAL);
         check("data_queue_empty", exp_data_q.size(), 0);
         check("addr_queue_empty", exp_addr_q.size(), 0);
`ifdef WEIGHT_LOADER_STAT_EN
         check("stall_cycles", stall_cycles, stalls);
`endif
         @(negedge clk);
         check("done_single_pulse", {31'd0, done}, 32'd0);
         check("idle_after_done", {31'd0, busy}, 32'd0);
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      start = 1'b0;
      fifo_almost_full = 1'b0;
      tile_base_m = '0;
      tile_base_n = '0;
      weight_base_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_rd_ena", {31'd0, rd_ena}, 32'd0);
      check("rst_rd_addr", {16'd0, rd_addr}, 32'd0);
      check("rst_push", {31'd0, fifo_push_tmp}, 32'd0);
      check("rst_data", data_to_fifo_tmp, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;

      // Full in-range tile.
      run_tile(0, 0, 16'h0100, 1'b0, -1, 0);
      check("nonzero_full", nonzero_seen, TOTAL);
      // Tile straddling the channel edge: only a 4x4 channel corner is in range.
      run_tile(28, 28, 16'h0200, 1'b0, -1, 0);
      check("nonzero_edge", nonzero_seen, 4 * 4 * 9);
      // Periodic back-pressure.
      run_tile(0, 0, 16'h0100, 1'b1, -1, 0);
      // Second start mid-tile is ignored.
      run_tile(0, 0, 16'h0300, 1'b0, 10, 0);
      // Reset mid-tile, then a clean tile.
      run_tile(0, 0, 16'h0100, 1'b0, -1, 100);
      run_tile(0, 0, 16'h0100, 1'b0, -1, 0);
      // Address wrap, with a start pulse during the done cycle.
      run_tile(0, 0, 16'hFFF0, 1'b0, TOTAL + RD_LAT + 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
